mont_mult_serial: RTL

//  Bit-serial radix-2 Montgomery multiplier. Computes z = x*y*2^-K mod M.

---
 rtl/mont_pkg.sv | 36 +++
 rtl/mont_cond_sub.sv | 21 ++
 rtl/mont_mult_serial.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mont_pkg.sv
// Shared constants and types for the bit-serial Montgomery multiplier and
// the modular-exponentiation controller that sits above it.
//   K, LOGK  operand width and iteration-counter width (2^LOGK > K)
//   M        odd modulus 2^192 - 2^64 - 1
//   ONE      the integer 1 at operand width
//   EXP_K    2^K mod M   (Montgomery form of 1)
//   EXP_2K   2^2K mod M  (multiply by this to enter Montgomery form)
//   MINUS_M  2^K - M     (adding it mod 2^K is the same as subtracting M)
//   state_t  multiplier FSM encoding
// No ports.
package mont_pkg;

  localparam int K    = 192;
  localparam int LOGK = 8;

  localparam logic [K-1:0] M =
    192'hffff_ffff_ffff_ffff_ffff_ffff_ffff_fffe_ffff_ffff_ffff_ffff;

  localparam logic [K-1:0] ONE = {{(K-1){1'b0}}, 1'b1};

  // With t = 2^64, M = t^3 - t - 1, so 2^K = t^3 == t + 1 (mod M).
  localparam logic [K-1:0] EXP_K = 192'h1_0000_0000_0000_0001;

  // (t + 1)^2 = t^2 + 2t + 1, already below M.
  localparam logic [K-1:0] EXP_2K =
    192'h1_0000_0000_0000_0002_0000_0000_0000_0001;

  localparam logic [K-1:0] MINUS_M = 192'h1_0000_0000_0000_0001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FINAL = 2'd2
  } state_t;

endpackage

// File: rtl/mont_cond_sub.sv
// Final conditional subtraction of a Montgomery result.
//   p  in  K+2  partial result, expected below 2M
//   r  out K    p >= M ? p - M : p
// Purely combinational. The low K bits of p - M are the low K bits of
// p + (2^K - M), so the subtractor only needs K bits; the compare still
// looks at all of p.
module mont_cond_sub
  import mont_pkg::*;
(
  input  logic [K+1:0] p,
  output logic [K-1:0] r
);

  logic         ge_m;
  logic [K-1:0] diff;

  assign ge_m = (p >= {2'b00, M});
  assign diff = p[K-1:0] + MINUS_M;
  assign r    = ge_m ? diff : p[K-1:0];

endmodule

// File: rtl/mont_mult_serial.sv
// Bit-serial radix-2 Montgomery multiplier: z = x * y * 2^-K mod M.
// One bit of x is consumed per clock; a result appears K+1 edges after the
// accepting edge.
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-high
//   x, y       in   K   operands (should be < M), captured on accept only
//   start      in   1   request, honoured only while idle
//   z          out  K   result, valid while done = 1
//   done       out  1   1 = idle with z valid, 0 = busy
//   state_dbg  out  2   current FSM state
//   range_err  out  1   only with MONT_MULT_RANGE_CHECK_EN defined: set on
//                       accept when x >= M or y >= M
// Optional feature macro: MONT_MULT_RANGE_CHECK_EN.
//
// Handshake: the engine is ready exactly when done = 1. A rising edge that
// sees start = 1 while ready is the accept; operands are sampled on that
// edge and done drops for the following K+1 cycles. start at any other time
// is ignored. If start stays high, the next op is accepted on the first
// edge after done rises, so done is high for one cycle between ops.
module mont_mult_serial
  import mont_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [K-1:0] x,
  input  logic [K-1:0] y,
  input  logic         start,
  output logic [K-1:0] z,
  output logic         done,
  output state_t       state_dbg
`ifdef MONT_MULT_RANGE_CHECK_EN
  ,
  output logic         range_err
`endif
);

  state_t          state;
  state_t          state_d;
  logic [K-1:0]    xr;
  logic [K-1:0]    yr;
  logic [K+1:0]    p;
  logic [LOGK-1:0] cnt;

  logic [K+1:0]    q_add;
  logic [K+1:0]    q_red;
  logic [K+1:0]    p_next;
  logic [K-1:0]    z_red;
  logic            accept;
  logic            last_iter;

  assign state_dbg = state;
  assign accept    = (state == IDLE) && start;
  assign last_iter = (cnt == LOGK'(K - 1));

  // One Montgomery step. Adding M when q is odd makes q even, so the
  // shift is exact and p stays below 2M for in-range operands.
  assign q_add  = p + (xr[cnt] ? {2'b00, yr} : {(K+2){1'b0}});
  assign q_red  = q_add + (q_add[0] ? {2'b00, M} : {(K+2){1'b0}});
  assign p_next = q_red >> 1;

  mont_cond_sub u_cond_sub (
    .p (p),
    .r (z_red)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start) state_d = ITER;
      ITER:    if (last_iter) state_d = FINAL;
      FINAL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xr   <= '0;
      yr   <= '0;
      p    <= '0;
      cnt  <= '0;
      z    <= '0;
      done <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            xr   <= x;
            yr   <= y;
            p    <= '0;
            cnt  <= '0;
            done <= 1'b0;
          end
        end
        ITER: begin
          p   <= p_next;
          cnt <= cnt + LOGK'(1);
        end
        FINAL: begin
          z    <= z_red;
          done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MONT_MULT_RANGE_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      range_err <= 1'b0;
    end else if (accept) begin
      range_err <= (x >= M) || (y >= M);
    end
  end
`endif

endmodule
